// File: rtl/wbseq_pkg.sv
// wbseq_pkg -- shared definitions for the writeback sequencer.
// Holds the default buffer depth, the result-size encodings, the layout of
// one buffered writeback packet and its total width, plus the helper that
// finds slots overridden by a later slot writing the same index.
package wbseq_pkg;

  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OPSZ_8  = 2'd0,
    OPSZ_16 = 2'd1,
    OPSZ_32 = 2'd2,
    OPSZ_64 = 2'd3
  } opsize_e;

  // Slot 1 of the external interface is element [0] of each array.
  typedef struct packed {
    logic [3:0][63:0] data;
    logic [3:0][15:0] segdata;
    logic [3:0][2:0]  addr;
    logic [3:0][2:0]  segaddr;
    opsize_e          opsize;
    logic [3:0]       regld;
    logic [3:0]       segld;
    logic [6:0]       ptcid;
  } wb_pkt_t;

  localparam int unsigned PKT_W = $bits(wb_pkt_t);

  // Bit i set when a higher-numbered enabled slot targets the same index,
  // so only the last writer of an index in a packet reaches the file.
  function automatic logic [3:0] dup_mask(input logic [3:0]      ld,
                                          input logic [3:0][2:0] idx);
    logic [3:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = i + 1; j < 4; j++) begin
        if (ld[j] && (idx[j] == idx[i])) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/wbseq_fifo.sv
// wbseq_fifo -- generic circular buffer with head/tail pointers and count.
// Ports:
//   clk, clr     clock, asynchronous active-low reset
//   flush        synchronous discard of all entries (wins over push/pop)
//   push, pop    requests; push ignored when full, pop ignored when empty
//   wdata/rdata  entry written at tail / entry presented at head
//   count        number of stored entries; full/empty decoded from it
// When empty, rdata keeps showing the last entry popped.
module wbseq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? last : mem[head];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= nxt(tail);
      if (do_pop)  head <= nxt(head);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage is not reset; validity is carried by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
    if (do_pop)  last      <= mem[head];
  end

endmodule

// File: rtl/wbseq.sv
// wbseq -- writeback sequencer between execute and the register/segment files.
// Buffers up to DEPTH execute results in order and presents the oldest one
// to the register file, masking duplicate targets inside a packet.
// Ports:
//   clk, clr             clock, asynchronous active-low reset
//   flush                drop every buffered packet at the next edge
//   in_valid/in_stall    execute-side handshake (stall = buffer full)
//   in_* fields          four result slots, op size, load enables, PTC id
//   wb_hold              register file refuses a write this cycle
//   wb_* fields          head packet fields
//   wb_regld/wb_segld    qualified write enables
//   occupancy            number of buffered packets
module wbseq
  import wbseq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_stall,
  input  logic [63:0]            in_data1,
  input  logic [63:0]            in_data2,
  input  logic [63:0]            in_data3,
  input  logic [63:0]            in_data4,
  input  logic [15:0]            in_segdata1,
  input  logic [15:0]            in_segdata2,
  input  logic [15:0]            in_segdata3,
  input  logic [15:0]            in_segdata4,
  input  logic [2:0]             in_addr1,
  input  logic [2:0]             in_addr2,
  input  logic [2:0]             in_addr3,
  input  logic [2:0]             in_addr4,
  input  logic [2:0]             in_segaddr1,
  input  logic [2:0]             in_segaddr2,
  input  logic [2:0]             in_segaddr3,
  input  logic [2:0]             in_segaddr4,
  input  logic [1:0]             in_opsize,
  input  logic [3:0]             in_regld,
  input  logic [3:0]             in_segld,
  input  logic [6:0]             in_ptcid,
  input  logic                   wb_hold,
  output logic [63:0]            wb_data1,
  output logic [63:0]            wb_data2,
  output logic [63:0]            wb_data3,
  output logic [63:0]            wb_data4,
  output logic [15:0]            wb_segdata1,
  output logic [15:0]            wb_segdata2,
  output logic [15:0]            wb_segdata3,
  output logic [15:0]            wb_segdata4,
  output logic [2:0]             wb_addr1,
  output logic [2:0]             wb_addr2,
  output logic [2:0]             wb_addr3,
  output logic [2:0]             wb_addr4,
  output logic [2:0]             wb_segaddr1,
  output logic [2:0]             wb_segaddr2,
  output logic [2:0]             wb_segaddr3,
  output logic [2:0]             wb_segaddr4,
  output logic [1:0]             wb_opsize,
  output logic [6:0]             wb_inst_ptcid,
  output logic [3:0]             wb_regld,
  output logic [3:0]             wb_segld,
  output logic [$clog2(DEPTH):0] occupancy
);

  wb_pkt_t    in_pkt;
  wb_pkt_t    head;
  logic       full;
  logic       empty;
  logic       go;
  logic [3:0] dup_r;
  logic [3:0] dup_s;

  always_comb begin
    in_pkt         = '0;
    in_pkt.data    = {in_data4, in_data3, in_data2, in_data1};
    in_pkt.segdata = {in_segdata4, in_segdata3, in_segdata2, in_segdata1};
    in_pkt.addr    = {in_addr4, in_addr3, in_addr2, in_addr1};
    in_pkt.segaddr = {in_segaddr4, in_segaddr3, in_segaddr2, in_segaddr1};
    in_pkt.opsize  = opsize_e'(in_opsize);
    in_pkt.regld   = in_regld;
    in_pkt.segld   = in_segld;
    in_pkt.ptcid   = in_ptcid;
  end

  wbseq_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .push  (in_valid),
    .pop   (!wb_hold),
    .wdata (in_pkt),
    .rdata (head),
    .count (occupancy),
    .full  (full),
    .empty (empty)
  );

  // Stall depends only on registered count, never on wb_hold.
  assign in_stall = full;

  // Enables are combinational from count, so they fall as soon as clr does.
  assign go    = !empty && !wb_hold;
  assign dup_r = dup_mask(head.regld, head.addr);
  assign dup_s = dup_mask(head.segld, head.segaddr);

  assign wb_regld = head.regld & ~dup_r & {4{go}};
  assign wb_segld = head.segld & ~dup_s & {4{go}};

  assign {wb_data4, wb_data3, wb_data2, wb_data1}             = head.data;
  assign {wb_segdata4, wb_segdata3, wb_segdata2, wb_segdata1} = head.segdata;
  assign {wb_addr4, wb_addr3, wb_addr2, wb_addr1}             = head.addr;
  assign {wb_segaddr4, wb_segaddr3, wb_segaddr2, wb_segaddr1} = head.segaddr;
  assign wb_opsize     = head.opsize;
  assign wb_inst_ptcid = head.ptcid;

endmodule
